ctrl_step_sequencer: RTL and testbench
======================================

// Module: ctrl_step_sequencer
// PURPOSE
//  Parametrised successor to the hard-wired multi-cycle control unit. Owns the fetch / execute /
//  interrupt / halt step sequencing and emits a step index for the external opcode decoder.
//  Adds memory wait-state handshaking, a bus-timeout watchdog, and interrupt entry at
//  instruction boundaries. Data-path strobes for execute steps stay in the decoder; this block
//  drives only fetch, interrupt-entry and run-status strobes.
// PARAMETERS
//  DATA_W    32        IR width
//  OPC_W     5         opcode field width, IR[DATA_W-1 -: OPC_W]
//  STEP_W    4         width of Step and ExecLen
//  MAX_STEPS 12        upper clamp on instruction length, in steps, including fetch steps 0..2
//  HALT_OPC  5'b11010  opcode that enters HALT
//  WAIT_MAX  16        MemReady wait cycles allowed before BusError; 0 disables the watchdog
// PORTS
//  Clock     in   1       rising-edge clock
//  Reset_n   in   1       asynchronous, active-low reset
//  IR        in   DATA_W  instruction register contents; valid from the first EXEC cycle
//  ExecLen   in   STEP_W  total steps of the current instruction (decoder output from IR)
//  MemReq    in   1       current EXEC step is a memory access (decoder output)
//  MemReady  in   1       memory completes the access in this cycle
//  Stop      in   1       request to halt
//  Resume    in   1       leave HALT (single-cycle pulse)
//  Interrupt in   1       level interrupt request
//  IntEnable in   1       interrupt mask; 1 = enabled
//  Step      out  STEP_W  current step index for decoder
//  Phase     out  2       00 FETCH, 01 EXEC, 10 INTR, 11 HALT/RESET
//  PCout, MARin, IncPC  out 1 each   fetch step 0 strobes
//  ReadEn, MDRin        out 1 each   fetch step 1 strobes
//  MDRout, IRin         out 1 each   fetch step 2 strobes
//  Stall     out  1       step held waiting on MemReady
//  IntAck    out  1       INTR0: acknowledge; save PC to link register
//  VecLoad   out  1       INTR1: load PC from the interrupt vector
//  Run       out  1       1 in every state except RESET and HALT
//  BusError  out  1       sticky watchdog flag; cleared only by reset
// BEHAVIOUR
//  - Moore machine: all outputs decode from registered state only.
//    States: RESET, F0, F1, F2, EXEC, INTR0, INTR1, HALT.
//  - Reset_n=0 forces RESET immediately. Every output is 0; Step=0, Phase=11.
//    Reset takes effect mid-wait and mid-instruction alike.
//  - RESET->F0 on the first edge after Reset_n releases.
//  - F0 (Step=0): PCout=MARin=IncPC=1 for 1 cycle, then F1.
//  - F1 (Step=1): ReadEn=MDRin=1. Holds until MemReady=1 is sampled, then F2.
//    Stall=1 while held.
//  - F2 (Step=2): MDRout=IRin=1 for 1 cycle, then EXEC with Step=3.
//  - EXEC:
//    - Effective length L = clamp(ExecLen, 4, MAX_STEPS).
//    - If IR opcode==HALT_OPC at Step 3, go to HALT.
//    - If MemReq=1 and MemReady=0, Step holds and Stall=1.
//    - Otherwise, if Step==L-1, go to the boundary; else Step+1.
//  - Boundary, at the end of EXEC: if Interrupt and IntEnable, go to INTR0; else F0.
//    Interrupts are sampled only here, never mid-instruction.
//  - INTR0 (IntAck=1) -> INTR1 (VecLoad=1) -> F0. One cycle each, Step=0.
//  - Watchdog: counter clears on entry to any waiting step and increments per stalled cycle.
//    When it reaches WAIT_MAX: BusError<=1 and next state is HALT.
//  - Stop=1 in any non-RESET state: next state is HALT. Stop overrides stall, boundary and
//    interrupt.
//  - HALT: Run=0 and every strobe is 0. Resume=1 and Stop=0 -> F0; otherwise stay.
//    Resume is ignored outside HALT.
//  - Priority per edge: Reset_n > Stop > watchdog > normal transition.
//  - Step never exceeds MAX_STEPS-1. The watchdog counter is ceil(log2(WAIT_MAX+1)) bits and
//    saturates.
// TESTING
//  - Reset, MemReady tied 1, ExecLen=5, non-halt IR:
//    Step sequence 0,1,2,3,4,0,... and each F-step strobe is high for exactly 1 cycle.
//  - MemReady low for 3 cycles in F1:
//    F1 lasts 4 cycles, Stall=1 for 3 cycles, BusError stays 0.
//  - WAIT_MAX=16, MemReq=1 and MemReady=0 at EXEC Step 3:
//    after 16 stall cycles BusError=1, Phase=11, Run=0. Resume then re-enters F0 with
//    BusError still 1.
//  - Interrupt=1 raised mid-EXEC, IntEnable=1:
//    the instruction completes, then IntAck and VecLoad fire for one cycle each, then F0.
//    With IntEnable=0: no INTR states.
//  - IR opcode=HALT_OPC: HALT after Step 3.
//    Stop pulse at Step 1: HALT on the next edge. Resume: F0 with Step=0.
//  - Reset_n pulsed low during an F1 stall:
//    every output 0 asynchronously, F0 one edge after release, ExecLen=0 -> clamped to L=4.

Source files
------------

// File: rtl/ctrl_step_sequencer.sv
// Step sequencer for a multi-cycle control unit: fetch (F0..F2), execute,
// interrupt entry and halt sequencing, with memory wait-state handshaking
// and a bus-timeout watchdog.
//
// state | meaning
// ------+-------------------------------------------------------------
// RESET | held in reset, all outputs low, Phase=11
// F0    | step 0: PC onto bus, MAR load, PC increment
// F1    | step 1: memory read into MDR, waits for mem_ready_i
// F2    | step 2: MDR into IR
// EXEC  | steps 3..L-1 driven by the external decoder
// INTR0 | interrupt acknowledge, PC saved to link register
// INTR1 | PC loaded from interrupt vector
// HALT  | stopped; left by resume_i, Phase=11

module ctrl_step_sequencer #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       OPC_W     = 5,
    parameter int unsigned       STEP_W    = 4,
    parameter int unsigned       MAX_STEPS = 12,
    parameter logic [OPC_W-1:0]  HALT_OPC  = 5'b11010,
    parameter int unsigned       WAIT_MAX  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] ir_i,
    input  logic [STEP_W-1:0] exec_len_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    input  logic              stop_i,
    input  logic              resume_i,
    input  logic              interrupt_i,
    input  logic              int_enable_i,
    output logic [STEP_W-1:0] step_o,
    output logic [1:0]        phase_o,
    output logic              pc_out_o,
    output logic              mar_in_o,
    output logic              inc_pc_o,
    output logic              read_en_o,
    output logic              mdr_in_o,
    output logic              mdr_out_o,
    output logic              ir_in_o,
    output logic              stall_o,
    output logic              int_ack_o,
    output logic              vec_load_o,
    output logic              run_o,
    output logic              bus_error_o
);

    localparam int unsigned         CNT_W     = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam bit                  WDOG_EN   = (WAIT_MAX != 0);
    localparam logic [CNT_W-1:0]    WDOG_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;
    localparam logic [STEP_W-1:0]   MIN_LEN   = STEP_W'(4);
    localparam logic [STEP_W-1:0]   MAX_LEN   = STEP_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_RESET, S_F0, S_F1, S_F2, S_EXEC, S_INTR0, S_INTR1, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              berr_q, berr_d;
    logic              stall_q, stall_d;
    logic [1:0]        phase_q, phase_d;
    logic              run_q, run_d;
    logic              f0_q, f0_d, f1_q, f1_d, f2_q, f2_d;
    logic              iack_q, iack_d, vload_q, vload_d;

    logic [STEP_W-1:0] len_eff;
    logic [STEP_W-1:0] last_step;
    logic [OPC_W-1:0]  opc;
    logic              hold;

    assign opc       = ir_i[DATA_W-1 -: OPC_W];
    assign last_step = len_eff - STEP_W'(1);

    // Effective instruction length, clamped so Step never passes MAX_STEPS-1
    always_comb begin
        if (exec_len_i < MIN_LEN)      len_eff = MIN_LEN;
        else if (exec_len_i > MAX_LEN) len_eff = MAX_LEN;
        else                           len_eff = exec_len_i;
    end

    // Next state, step, watchdog and output decode; Stop beats watchdog beats normal flow
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = '0;
        berr_d  = berr_q;
        stall_d = 1'b0;
        hold    = 1'b0;

        case (state_q)
            S_RESET: begin state_d = S_F0; step_d = '0; end
            S_F0:    begin state_d = S_F1; step_d = STEP_W'(1); end
            S_F1: begin
                if (mem_ready_i) begin
                    state_d = S_F2;
                    step_d  = STEP_W'(2);
                end else begin
                    hold = 1'b1;
                end
            end
            S_F2:    begin state_d = S_EXEC; step_d = STEP_W'(3); end
            S_EXEC: begin
                if (step_q == STEP_W'(3) && opc == HALT_OPC) begin
                    state_d = S_HALT;
                    step_d  = '0;
                end else if (mem_req_i && !mem_ready_i) begin
                    hold = 1'b1;
                end else if (step_q >= last_step) begin
                    // interrupts are only taken at an instruction boundary
                    state_d = (interrupt_i && int_enable_i) ? S_INTR0 : S_F0;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            S_INTR0: begin state_d = S_INTR1; step_d = '0; end
            S_INTR1: begin state_d = S_F0;    step_d = '0; end
            S_HALT: begin
                step_d = '0;
                if (resume_i && !stop_i) state_d = S_F0;
            end
            default: begin state_d = S_RESET; step_d = '0; end
        endcase

        if (hold) begin
            stall_d = 1'b1;
            cnt_d   = (cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
            if (WDOG_EN && cnt_q == WDOG_LAST) begin
                state_d = S_HALT;
                step_d  = '0;
                berr_d  = 1'b1;
                stall_d = 1'b0;
                cnt_d   = '0;
            end
        end

        if (stop_i && state_q != S_RESET) begin
            state_d = S_HALT;
            step_d  = '0;
            stall_d = 1'b0;
            cnt_d   = '0;
        end

        phase_d = 2'b11;
        run_d   = 1'b1;
        f0_d    = (state_d == S_F0);
        f1_d    = (state_d == S_F1);
        f2_d    = (state_d == S_F2);
        iack_d  = (state_d == S_INTR0);
        vload_d = (state_d == S_INTR1);
        case (state_d)
            S_F0, S_F1, S_F2:  phase_d = 2'b00;
            S_EXEC:            phase_d = 2'b01;
            S_INTR0, S_INTR1:  phase_d = 2'b10;
            default: begin
                phase_d = 2'b11;
                run_d   = 1'b0;
            end
        endcase
    end

    // State and registered Moore outputs; reset clears everything immediately
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_RESET;
            step_q  <= '0;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
            stall_q <= 1'b0;
            phase_q <= 2'b11;
            run_q   <= 1'b0;
            f0_q    <= 1'b0;
            f1_q    <= 1'b0;
            f2_q    <= 1'b0;
            iack_q  <= 1'b0;
            vload_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
            stall_q <= stall_d;
            phase_q <= phase_d;
            run_q   <= run_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            iack_q  <= iack_d;
            vload_q <= vload_d;
        end
    end

    assign step_o      = step_q;
    assign phase_o     = phase_q;
    assign pc_out_o    = f0_q;
    assign mar_in_o    = f0_q;
    assign inc_pc_o    = f0_q;
    assign read_en_o   = f1_q;
    assign mdr_in_o    = f1_q;
    assign mdr_out_o   = f2_q;
    assign ir_in_o     = f2_q;
    assign stall_o     = stall_q;
    assign int_ack_o   = iack_q;
    assign vec_load_o  = vload_q;
    assign run_o       = run_q;
    assign bus_error_o = berr_q;

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Testbench for ctrl_step_sequencer: directed phases plus randomized inputs,
// every cycle compared against a behavioural model of the step rules.
module tb_ctrl_step_sequencer;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned MAX_STEPS = 12;
    localparam int unsigned WAIT_MAX  = 16;
    localparam logic [4:0]  HALT_OPC  = 5'b11010;

    localparam int MD_RST = 0, MD_F = 1, MD_X = 2, MD_I = 3, MD_H = 4;
    localparam int ST_CLEAN = 0, ST_RAND = 1, ST_STARVE = 2, ST_CLEAN0 = 3,
                   ST_INT = 4, ST_NOINT = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] ir = '0;
    logic [STEP_W-1:0] exec_len = '0;
    logic              mem_req = 1'b0, mem_ready = 1'b0, stop = 1'b0, resume = 1'b0;
    logic              interrupt = 1'b0, int_enable = 1'b0;
    logic [STEP_W-1:0] step;
    logic [1:0]        phase;
    logic pc_out, mar_in, inc_pc, read_en, mdr_in, mdr_out, ir_in;
    logic stall, int_ack, vec_load, run, bus_error;

    int total = 0, passed = 0, failed = 0;

    // behavioural model state
    int m_mode = MD_RST, m_step = 0, m_sub = 0, m_wait = 0;
    bit m_stall = 0, m_berr = 0;

    ctrl_step_sequencer #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS),
        .HALT_OPC(HALT_OPC), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ir_i(ir), .exec_len_i(exec_len),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .stop_i(stop), .resume_i(resume),
        .interrupt_i(interrupt), .int_enable_i(int_enable),
        .step_o(step), .phase_o(phase), .pc_out_o(pc_out), .mar_in_o(mar_in),
        .inc_pc_o(inc_pc), .read_en_o(read_en), .mdr_in_o(mdr_in), .mdr_out_o(mdr_out),
        .ir_in_o(ir_in), .stall_o(stall), .int_ack_o(int_ack), .vec_load_o(vec_load),
        .run_o(run), .bus_error_o(bus_error)
    );

    always #5 clk = ~clk;

    function automatic int eff_len(input int e);
        if (e < 4) return 4;
        if (e > int'(MAX_STEPS)) return int'(MAX_STEPS);
        return e;
    endfunction

    task automatic model_reset();
        m_mode = MD_RST; m_step = 0; m_sub = 0; m_wait = 0; m_stall = 0; m_berr = 0;
    endtask

    // advance the model across one rising edge using the inputs now applied
    task automatic model_edge();
        int  prev;
        bit  wt;
        logic [OPC_W-1:0] op;
        prev = m_mode;
        wt   = 0;
        op   = ir[DATA_W-1 -: OPC_W];
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            MD_RST: begin m_mode = MD_F; m_step = 0; end
            MD_F: begin
                if (m_step == 0) m_step = 1;
                else if (m_step == 1) begin
                    if (mem_ready) m_step = 2; else wt = 1;
                end else begin
                    m_mode = MD_X; m_step = 3;
                end
            end
            MD_X: begin
                if (m_step == 3 && op == HALT_OPC) begin
                    m_mode = MD_H; m_step = 0;
                end else if (mem_req && !mem_ready) begin
                    wt = 1;
                end else if (m_step >= eff_len(int'(exec_len)) - 1) begin
                    m_step = 0;
                    if (interrupt && int_enable) begin m_mode = MD_I; m_sub = 0; end
                    else m_mode = MD_F;
                end else begin
                    m_step = m_step + 1;
                end
            end
            MD_I: begin
                if (m_sub == 0) m_sub = 1; else m_mode = MD_F;
            end
            default: begin
                if (resume && !stop) m_mode = MD_F;
            end
        endcase
        m_stall = 0;
        if (wt) begin
            m_wait = m_wait + 1;
            if (WAIT_MAX > 0 && m_wait >= int'(WAIT_MAX)) begin
                m_berr = 1; m_mode = MD_H; m_step = 0; m_wait = 0;
            end else begin
                m_stall = 1;
            end
        end else begin
            m_wait = 0;
        end
        if (stop && prev != MD_RST) begin
            m_mode = MD_H; m_step = 0; m_stall = 0; m_wait = 0;
        end
    endtask

    function automatic logic [8:0] exp_strobes();
        if (m_mode == MD_F && m_step == 0) return 9'b111_00_00_00;
        if (m_mode == MD_F && m_step == 1) return 9'b000_11_00_00;
        if (m_mode == MD_F && m_step == 2) return 9'b000_00_11_00;
        if (m_mode == MD_I && m_sub == 0)  return 9'b000_00_00_10;
        if (m_mode == MD_I && m_sub == 1)  return 9'b000_00_00_01;
        return 9'b0;
    endfunction

    function automatic logic [1:0] exp_phase();
        case (m_mode)
            MD_F:    return 2'b00;
            MD_X:    return 2'b01;
            MD_I:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string ctx);
        logic [8:0] strb;
        strb = {pc_out, mar_in, inc_pc, read_en, mdr_in, mdr_out, ir_in, int_ack, vec_load};
        chk({ctx, ".step"},    32'(step),      32'(m_step));
        chk({ctx, ".phase"},   32'(phase),     32'(exp_phase()));
        chk({ctx, ".strobes"}, 32'(strb),      32'(exp_strobes()));
        chk({ctx, ".stall"},   32'(stall),     32'(m_stall));
        chk({ctx, ".run"},     32'(run),       32'(m_mode != MD_RST && m_mode != MD_H));
        chk({ctx, ".buserr"},  32'(bus_error), 32'(m_berr));
    endtask

    task automatic drive(input int mode);
        case (mode)
            ST_CLEAN, ST_CLEAN0, ST_INT, ST_NOINT: begin
                mem_ready = 1; mem_req = 0; stop = 0; resume = 1;
                exec_len = (mode == ST_CLEAN0) ? 4'd0 : 4'd5;
                ir = {5'b00001, 27'(int'($urandom))};
                interrupt = (mode == ST_INT || mode == ST_NOINT);
                int_enable = (mode == ST_INT);
            end
            ST_STARVE: begin
                mem_ready = 0; mem_req = 1; stop = 0; resume = 0;
                exec_len = 4'd6; ir = {5'b00010, 27'd0};
                interrupt = 0; int_enable = 0;
            end
            default: begin
                mem_ready  = ($urandom_range(0, 3) != 0);
                mem_req    = 1'($urandom_range(0, 1));
                stop       = ($urandom_range(0, 47) == 0);
                resume     = ($urandom_range(0, 3) == 0);
                interrupt  = 1'($urandom_range(0, 1));
                int_enable = 1'($urandom_range(0, 1));
                exec_len   = 4'($urandom_range(0, 15));
                ir         = $urandom;
                if ($urandom_range(0, 7) == 0) ir[DATA_W-1 -: OPC_W] = HALT_OPC;
            end
        endcase
    endtask

    task automatic run_cycles(input int n, input int mode, input string ctx);
        for (int i = 0; i < n; i++) begin
            drive(mode);
            model_edge();
            @(posedge clk);
            #1;
            chk_all(ctx);
        end
    endtask

    task automatic async_reset(input string ctx);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all({ctx, ".async"});
        run_cycles(2, ST_CLEAN0, {ctx, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rst_n = 1'b1;

        run_cycles(20, ST_CLEAN, "clean");

        // F1 wait states below the watchdog limit
        run_cycles(1, ST_CLEAN, "to_f1");
        run_cycles(3, ST_STARVE, "f1_wait");
        run_cycles(12, ST_CLEAN, "f1_done");

        run_cycles(30, ST_INT, "int_en");
        run_cycles(30, ST_NOINT, "int_dis");

        // let an EXEC memory step starve until the watchdog trips
        while (!(m_mode == MD_X && m_step == 3)) run_cycles(1, ST_CLEAN, "to_exec");
        run_cycles(20, ST_STARVE, "starve");
        chk("wdog.buserr", 32'(bus_error), 32'd1);
        chk("wdog.phase",  32'(phase),     32'd3);
        run_cycles(8, ST_CLEAN, "resume");
        chk("sticky.buserr", 32'(bus_error), 32'd1);

        // reset during an F1 stall, then the clamped ExecLen=0 path
        while (!(m_mode == MD_F && m_step == 1)) run_cycles(1, ST_CLEAN, "to_f1b");
        run_cycles(2, ST_STARVE, "f1_stall");
        async_reset("rst_f1");
        run_cycles(12, ST_CLEAN0, "clamp4");

        for (int k = 0; k < 6; k++) begin
            run_cycles(400, ST_RAND, "rand");
            run_cycles(20, ST_STARVE, "rstarve");
            async_reset("rrst");
        end
        run_cycles(100, ST_RAND, "tail");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
